// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state type and stream framing constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: packs a little-endian byte stream into 32-bit words.
// Ports: clock/reset (async, active-high); clear restarts the group; push/in_byte shift one byte in;
// full is high while the next push completes a word, and word is that completed word.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        full
);
    logic [1:0]  cnt;
    logic [23:0] sr;
    // The final byte of a group goes straight into word[31:24], so the caller can
    // register the complete word on the same edge the last byte is accepted.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            cnt <= '0;
            sr  <= '0;
        end else if (clear) begin
            cnt <= '0;
            sr  <= '0;
        end else if (push) begin
            cnt <= cnt + 2'd1;
            sr  <= {in_byte, sr[23:8]};
        end
    assign full = cnt == 2'(BYTES_PER_WORD - 1);
    assign word = {in_byte, sr};
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory while holding the core.
// Ports: clock/reset (async, active-high); start begins a load from IDLE/DONE/ERROR;
// in_valid/in_byte/in_ready byte stream; wr_en/wr_addr/wr_data memory write port;
// cpu_hold stalls fetch; busy/done/error report load status.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 16,
    parameter int CNT_W       = 16
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t                   state, state_nx;
    logic [CNT_W-1:0]         count, word_idx;
    logic [7:0]               len_lo;
    logic [LEN_BYTES*8-1:0]   hdr;
    logic                     take, start_go, pk_push, pk_full;
    logic [31:0]              pk_word;

    assign in_ready = state inside {S_LEN_LO, S_LEN_HI, S_DATA};
    assign take     = in_valid & in_ready;
    assign start_go = start & (state inside {S_IDLE, S_DONE, S_ERROR});
    assign pk_push  = take & (state == S_DATA);
    assign hdr      = {in_byte, len_lo};

    assign wr_en    = state == S_WRITE;
    assign busy     = state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE};
    assign done     = state == S_DONE;
    assign error    = state == S_ERROR;
    // ERROR keeps the hold: the memory may contain a partial image.
    assign cpu_hold = !(state inside {S_IDLE, S_DONE});

    imem_word_packer u_packer (
        .clock   (clock),
        .reset   (reset),
        .clear   (start_go),
        .push    (pk_push),
        .in_byte (in_byte),
        .word    (pk_word),
        .full    (pk_full)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= S_IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: state_nx = start ? S_LEN_LO : state;
            S_LEN_LO: state_nx = take ? S_LEN_HI : state;
            S_LEN_HI: state_nx = !take                    ? state   :
                                 hdr == '0                ? S_DONE  :
                                 CNT_W'(hdr) > DEPTH_C    ? S_ERROR : S_DATA;
            S_DATA:   state_nx = (take && pk_full) ? S_WRITE : state;
            S_WRITE:  state_nx = (word_idx + ONE == count) ? S_DONE : S_DATA;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Write address/data are captured as the last byte arrives so they are
    // stable for the whole WRITE cycle and hold afterwards.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            count    <= '0;
            word_idx <= '0;
            len_lo   <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            if (start_go) begin
                count    <= '0;
                word_idx <= '0;
            end
            if (take && state == S_LEN_LO) len_lo <= in_byte;
            if (take && state == S_LEN_HI) count <= CNT_W'(hdr);
            if (pk_push && pk_full) begin
                wr_data <= pk_word;
                wr_addr <= 32'(word_idx) * BYTES_PER_WORD;
            end
            if (state == S_WRITE) word_idx <= word_idx + ONE;
        end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;
    logic        clock = 0;
    logic        reset, start, in_valid;
    logic [7:0]  in_byte;
    logic        in_ready, wr_en, cpu_hold, busy, done, error;
    logic [31:0] wr_addr, wr_data;

    int          tests = 0;
    int          fails = 0;
    int          nwr = 0;
    int          n0;
    logic [31:0] mem [16];
    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];
    logic [7:0]  basic [12] = '{8'hb3, 8'h81, 8'h20, 8'h00, 8'hb3, 8'h82, 8'h41, 8'h40,
                                8'hb3, 8'hc3, 8'h61, 8'h00};

    imem_loader dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (!reset && wr_en) begin
            mem[wr_addr[5:2]] = wr_data;
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            nwr++;
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        in_valid = 1;
        in_byte  = b;
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %h never accepted", b);
        end
        @(posedge clock);
        #1 in_valid = 0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1;
        @(posedge clock);
        #1 start = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_wr_en"},    32'(wr_en),    0);
        chk({tag, "_wr_addr"},  wr_addr,       0);
        chk({tag, "_wr_data"},  wr_data,       0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
        chk({tag, "_busy"},     32'(busy),     0);
        chk({tag, "_done"},     32'(done),     0);
        chk({tag, "_error"},    32'(error),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; start = 0; in_valid = 0; in_byte = 0;
        foreach (mem[i]) mem[i] = '0;
        repeat (2) @(posedge clock);
        #1 chk_reset_vals("rst");
        @(negedge clock) reset = 0;
        // basic three-word load
        pulse_start();
        chk("basic_busy", 32'(busy), 1);
        chk("basic_hold", 32'(cpu_hold), 1);
        chk("basic_ready", 32'(in_ready), 1);
        send(8'h03, 0);
        send(8'h00, 0);
        foreach (basic[i]) send(basic[i], 0);
        chk("basic_wr_en", 32'(wr_en), 1);
        chk("basic_wr_ready", 32'(in_ready), 0);
        chk("basic_wr_addr", wr_addr, 32'h8);
        chk("basic_wr_data", wr_data, 32'h0061c3b3);
        @(posedge clock); #1;
        chk("basic_done", 32'(done), 1);
        chk("basic_hold_off", 32'(cpu_hold), 0);
        chk("basic_busy_off", 32'(busy), 0);
        chk("basic_addr_hold", wr_addr, 32'h8);
        chk("basic_nwr", nwr, 3);
        chk("basic_a0", wa_q[0], 32'h0);
        chk("basic_a1", wa_q[1], 32'h4);
        chk("basic_a2", wa_q[2], 32'h8);
        chk("basic_m0", mem[0], 32'h002081b3);
        chk("basic_m1", mem[1], 32'h404182b3);
        chk("basic_m2", mem[2], 32'h0061c3b3);
        // zero-length header
        pulse_start();
        chk("zero_done_clr", 32'(done), 0);
        send(8'h00, 0);
        send(8'h00, 0);
        chk("zero_done", 32'(done), 1);
        chk("zero_hold", 32'(cpu_hold), 0);
        chk("zero_error", 32'(error), 0);
        chk("zero_nwr", nwr, 3);
        // oversize header
        pulse_start();
        send(8'h11, 0);
        send(8'h00, 0);
        chk("over_error", 32'(error), 1);
        chk("over_hold", 32'(cpu_hold), 1);
        chk("over_ready", 32'(in_ready), 0);
        chk("over_done", 32'(done), 0);
        chk("over_busy", 32'(busy), 0);
        chk("over_nwr", nwr, 3);
        pulse_start();
        chk("over_clr_error", 32'(error), 0);
        chk("over_clr_busy", 32'(busy), 1);
        // one-word load with random gaps
        send(8'h01, $urandom_range(0, 3));
        send(8'h00, $urandom_range(0, 3));
        send(8'h13, $urandom_range(0, 3));
        send(8'h00, $urandom_range(0, 3));
        send(8'h00, $urandom_range(0, 3));
        send(8'h00, $urandom_range(0, 3));
        chk("gap_wr_en", 32'(wr_en), 1);
        chk("gap_ready_write", 32'(in_ready), 0);
        @(posedge clock); #1;
        chk("gap_done", 32'(done), 1);
        chk("gap_nwr", nwr, 4);
        chk("gap_addr", wa_q[$], 32'h0);
        chk("gap_data", wd_q[$], 32'h00000013);
        // reset in the middle of a two-word load
        n0 = nwr;
        pulse_start();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        send(8'h44, 0);
        send(8'h55, 0);
        send(8'h66, 0);
        #1 reset = 1;
        #1 chk_reset_vals("midrst");
        chk("midrst_nwr", nwr - n0, 1);
        chk("midrst_addr", wa_q[$], 32'h0);
        chk("midrst_data", wd_q[$], 32'h44332211);
        @(negedge clock) reset = 0;
        pulse_start();
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'haa, 0);
        send(8'hbb, 0);
        send(8'hcc, 0);
        send(8'hdd, 0);
        @(posedge clock); #1;
        chk("fresh_done", 32'(done), 1);
        chk("fresh_nwr", nwr - n0, 2);
        chk("fresh_data", mem[0], 32'hddccbbaa);
        // start pulse during DATA must be ignored
        n0 = nwr;
        pulse_start();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        pulse_start();
        chk("sbusy_busy", 32'(busy), 1);
        send(8'h03, 0);
        send(8'h04, 0);
        send(8'h05, 0);
        send(8'h06, 0);
        send(8'h07, 0);
        send(8'h08, 0);
        @(posedge clock); #1;
        chk("sbusy_done", 32'(done), 1);
        chk("sbusy_error", 32'(error), 0);
        chk("sbusy_nwr", nwr - n0, 2);
        chk("sbusy_a1", wa_q[$], 32'h4);
        chk("sbusy_m0", mem[0], 32'h04030201);
        chk("sbusy_m1", mem[1], 32'h08070605);
        chk("sbusy_m2", mem[2], 32'h0061c3b3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
